// File: rtl/bt_uart_tx_fifo.sv
// Buffered 8N1 UART transmitter feeding the RN4871 RXD pin.
// Bytes are queued in a small FIFO and sent back-to-back, LSB first,
// each bit held for CLKS_PER_BIT clocks. All outputs are registered.
module bt_uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_L,
    input  logic                          i_TX_DV,
    input  logic [7:0]                    i_TX_Byte,
    output logic                          o_TX_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count,
    output logic                          o_Overflow,
    output logic                          o_TX_Active,
    output logic                          o_TX_Serial,
    output logic                          o_TX_Done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_n;
    logic          push;
    logic          pop;

    state_t        state;
    state_t        state_n;
    logic [BW-1:0] baud;
    logic [BW-1:0] baud_n;
    logic [2:0]    idx;
    logic [2:0]    idx_n;
    logic [7:0]    shift;
    logic [7:0]    shift_n;
    logic          line;
    logic          done_n;

    // A write is judged against the pre-edge count only, so a pop in the
    // same cycle never makes room for a write attempted while full.
    assign push         = i_TX_DV && (count < DEPTH_C);
    assign o_FIFO_Count = count;

    // Occupancy after this edge's push/pop
    always_comb begin
        count_n = count;
        if (push && !pop) begin
            count_n = count + 1'b1;
        end else if (!push && pop) begin
            count_n = count - 1'b1;
        end
    end

    // FIFO storage: written at the tail on every accepted byte
    always_ff @(posedge i_Clk) begin
        if (push) begin
            mem[wr_ptr] <= i_TX_Byte;
        end
    end

    // FIFO pointers, occupancy, ready and sticky overflow flag
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_TX_Ready <= 1'b1;
            o_Overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count      <= count_n;
            o_TX_Ready <= (count_n < DEPTH_C);
            if (i_TX_DV && !(count < DEPTH_C)) begin
                o_Overflow <= 1'b1;
            end
        end
    end

    // Transmit state machine registers
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state <= IDLE;
            baud  <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            state <= state_n;
            baud  <= baud_n;
            idx   <= idx_n;
            shift <= shift_n;
        end
    end

    // Next-state, bit timing, FIFO pop and line level
    always_comb begin
        state_n = state;
        baud_n  = baud;
        idx_n   = idx;
        shift_n = shift;
        pop     = 1'b0;
        line    = 1'b1;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                line   = 1'b1;
                baud_n = '0;
                idx_n  = '0;
                if (count != '0) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    state_n = START;
                end
            end
            START: begin
                line = 1'b0;
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    idx_n   = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            DATA: begin
                line = shift[idx];
                if (baud == BAUD_LAST) begin
                    baud_n = '0;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            STOP: begin
                line = 1'b1;
                if (baud == BAUD_LAST) begin
                    baud_n = '0;
                    done_n = 1'b1;
                    // Chain straight into the next start bit when more is queued
                    if (count != '0) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        idx_n   = '0;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
        endcase
    end

    // Registered line outputs: one cycle behind the state register, so the
    // serial frame, active window and done pulse stay mutually aligned.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_TX_Serial <= 1'b1;
            o_TX_Active <= 1'b0;
            o_TX_Done   <= 1'b0;
        end else begin
            o_TX_Serial <= line;
            o_TX_Active <= (state != IDLE);
            o_TX_Done   <= done_n;
        end
    end

endmodule

// File: tb/tb_bt_uart_tx_fifo.sv
// Self-checking bench for bt_uart_tx_fifo (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A line monitor decodes frames into a received queue; each test pushes the
// bytes it expects and compares them against decoded frames.
module tb_bt_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int FRAME = 10 * CPB;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          dv      = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          ready;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          active;
    logic          serial;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] data;
        bit         ok;
        int         start;
    } frame_t;

    frame_t     got_q[$];
    logic [7:0] exp_q[$];

    int         mon_pos   = -1;
    int         mon_start = 0;
    logic [FRAME-1:0] fbits;
    int         act_cnt  = 0;
    int         act_rise = 0;
    int         done_cnt = 0;
    logic       act_prev = 1'b0;

    bt_uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_TX_DV     (dv),
        .i_TX_Byte   (byte_in),
        .o_TX_Ready  (ready),
        .o_FIFO_Count(fifo_count),
        .o_Overflow  (overflow),
        .o_TX_Active (active),
        .o_TX_Serial (serial),
        .o_TX_Done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: samples mid-cycle, decodes 8N1 frames, tracks activity
    always @(negedge clk) begin
        frame_t f;
        if (!rst_n) begin
            mon_pos  = -1;
            act_prev = 1'b0;
        end else begin
            if (active) act_cnt++;
            if (active && !act_prev) act_rise++;
            act_prev = active;
            if (done) done_cnt++;
            if (mon_pos < 0) begin
                if (serial === 1'b0) begin
                    fbits[0]  = 1'b0;
                    mon_pos   = 1;
                    mon_start = cyc;
                end
            end else begin
                fbits[mon_pos] = serial;
                mon_pos++;
                if (mon_pos == FRAME) begin
                    f.ok    = 1'b1;
                    f.start = mon_start;
                    if (fbits[0] !== 1'b0 || fbits[9*CPB] !== 1'b1) f.ok = 1'b0;
                    for (int b = 0; b < 10; b++)
                        for (int s = 1; s < CPB; s++)
                            if (fbits[b*CPB+s] !== fbits[b*CPB]) f.ok = 1'b0;
                    for (int i = 0; i < 8; i++) f.data[i] = fbits[(i+1)*CPB];
                    got_q.push_back(f);
                    mon_pos = -1;
                end
            end
        end
    end

    // Wait until the transmitter has been active and has gone fully quiet
    task automatic wait_quiet(input int budget, output bit timed_out);
        bit seen = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (active) seen = 1'b1;
            if (seen && !active && fifo_count == '0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dv    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({serial, ready, overflow, active, done} !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_outputs: got ser/rdy/ovf/act/done=%b required 11000",
                     {serial, ready, overflow, active, done});
        end
        n_checks++;
        if (fifo_count !== '0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d required 0", fifo_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({serial, ready, active, fifo_count} !== {3'b110, CW'(0)}) begin
            n_fail++;
            $display("FAIL reset_release_idle: got ser=%b rdy=%b act=%b cnt=%0d required 1 1 0 0",
                     serial, ready, active, fifo_count);
        end
    endtask

    task automatic test_single();
        int a0, r0, d0;
        bit to;
        frame_t f;
        a0 = act_cnt; r0 = act_rise; d0 = done_cnt;
        byte_in = 8'h35; dv = 1'b1;
        exp_q.push_back(8'h35);
        @(posedge clk); #1;
        dv = 1'b0;
        n_checks++;
        if (fifo_count !== CW'(1) || serial !== 1'b1) begin
            n_fail++;
            $display("FAIL single_accept: got cnt=%0d ser=%b required 1 1", fifo_count, serial);
        end
        @(posedge clk); #1;
        n_checks++;
        if (serial !== 1'b1 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL single_edge1: got ser=%b act=%b required 1 0", serial, active);
        end
        @(posedge clk); #1;
        n_checks++;
        if (serial !== 1'b0 || active !== 1'b1) begin
            n_fail++;
            $display("FAIL single_edge2: got ser=%b act=%b required 0 1", serial, active);
        end
        wait_quiet(200, to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL single_timeout: transmitter did not go idle, required idle within 200 cycles");
        end
        n_checks++;
        if (act_cnt - a0 != 40 || act_rise - r0 != 1 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL single_activity: got act=%0d rises=%0d done=%0d required 40 1 1",
                     act_cnt - a0, act_rise - r0, done_cnt - d0);
        end
        n_checks++;
        if (fifo_count !== '0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_drain: got cnt=%0d rdy=%b required 0 1", fifo_count, ready);
        end
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin
                n_fail++;
                $display("FAIL single_frame: got no frame required %h", e);
            end else begin
                f = got_q.pop_front();
                if (f.data !== e || !f.ok) begin
                    n_fail++;
                    $display("FAIL single_frame: got %h well_formed=%0d required %h well_formed=1",
                             f.data, f.ok, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] burst [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        int a0, r0, d0, prev_start;
        bit to;
        frame_t f;
        a0 = act_cnt; r0 = act_rise; d0 = done_cnt;
        prev_start = -1;
        for (int i = 0; i < 4; i++) begin
            byte_in = burst[i]; dv = 1'b1;
            exp_q.push_back(burst[i]);
            @(posedge clk); #1;
        end
        dv = 1'b0;
        n_checks++;
        if (fifo_count !== CW'(3)) begin
            n_fail++;
            $display("FAIL burst_count: got %0d required 3", fifo_count);
        end
        wait_quiet(400, to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL burst_timeout: transmitter did not go idle, required idle within 400 cycles");
        end
        n_checks++;
        if (act_cnt - a0 != 160 || act_rise - r0 != 1 || done_cnt - d0 != 4) begin
            n_fail++;
            $display("FAIL burst_activity: got act=%0d rises=%0d done=%0d required 160 1 4",
                     act_cnt - a0, act_rise - r0, done_cnt - d0);
        end
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin
                n_fail++;
                $display("FAIL burst_frame: got no frame required %h", e);
            end else begin
                f = got_q.pop_front();
                if (f.data !== e || !f.ok || (prev_start >= 0 && f.start - prev_start != FRAME)) begin
                    n_fail++;
                    $display("FAIL burst_frame: got %h ok=%0d gap=%0d required %h ok=1 gap=%0d",
                             f.data, f.ok, f.start - prev_start, e, FRAME);
                end
                prev_start = f.start;
            end
        end
    endtask

    task automatic test_overflow();
        int exp_cnt [6] = '{1, 1, 2, 3, 4, 4};
        logic exp_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic exp_ovf [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int d0;
        bit to;
        frame_t f;
        d0 = done_cnt;
        for (int i = 0; i < 6; i++) begin
            byte_in = 8'(i + 1); dv = 1'b1;
            if (i < 5) exp_q.push_back(8'(i + 1));
            @(posedge clk); #1;
            n_checks++;
            if (fifo_count !== CW'(exp_cnt[i]) || ready !== exp_rdy[i] || overflow !== exp_ovf[i]) begin
                n_fail++;
                $display("FAIL overflow_fill[%0d]: got cnt=%0d rdy=%b ovf=%b required %0d %b %b",
                         i, fifo_count, ready, overflow, exp_cnt[i], exp_rdy[i], exp_ovf[i]);
            end
        end
        dv = 1'b0;
        wait_quiet(600, to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL overflow_timeout: transmitter did not go idle, required idle within 600 cycles");
        end
        n_checks++;
        if (overflow !== 1'b1 || ready !== 1'b1 || done_cnt - d0 != 5) begin
            n_fail++;
            $display("FAIL overflow_sticky: got ovf=%b rdy=%b done=%0d required 1 1 5",
                     overflow, ready, done_cnt - d0);
        end
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin
                n_fail++;
                $display("FAIL overflow_frame: got no frame required %h", e);
            end else begin
                f = got_q.pop_front();
                if (f.data !== e || !f.ok) begin
                    n_fail++;
                    $display("FAIL overflow_frame: got %h ok=%0d required %h ok=1", f.data, f.ok, e);
                end
            end
        end
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("FAIL overflow_extra: got %0d extra frames required 0", got_q.size());
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int c0, prev_start;
        bit to;
        frame_t f;
        prev_start = -1;
        for (int i = 0; i < 3; i++) begin
            byte_in = bytes[i]; dv = 1'b1;
            exp_q.push_back(bytes[i]);
            @(posedge clk); #1;
            if (i == 0) c0 = cyc;
        end
        dv = 1'b0;
        exp_q.push_back(bytes[3]);
        for (int i = 0; i < 100 && cyc < c0 + 40; i++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (fifo_count !== CW'(2)) begin
            n_fail++;
            $display("FAIL simul_before: got cnt=%0d required 2", fifo_count);
        end
        byte_in = bytes[3]; dv = 1'b1;
        @(posedge clk); #1;
        dv = 1'b0;
        n_checks++;
        if (fifo_count !== CW'(2) || done !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_pop_push: got cnt=%0d done=%b required 2 1", fifo_count, done);
        end
        wait_quiet(600, to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL simul_timeout: transmitter did not go idle, required idle within 600 cycles");
        end
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin
                n_fail++;
                $display("FAIL simul_frame: got no frame required %h", e);
            end else begin
                f = got_q.pop_front();
                if (f.data !== e || !f.ok || (prev_start >= 0 && f.start - prev_start != FRAME)) begin
                    n_fail++;
                    $display("FAIL simul_frame: got %h ok=%0d gap=%0d required %h ok=1 gap=%0d",
                             f.data, f.ok, f.start - prev_start, e, FRAME);
                end
                prev_start = f.start;
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] bytes [3] = '{8'h55, 8'hAA, 8'h0F};
        int c0, g0, bad;
        bit to;
        frame_t f;
        for (int i = 0; i < 3; i++) begin
            byte_in = bytes[i]; dv = 1'b1;
            @(posedge clk); #1;
            if (i == 0) c0 = cyc;
        end
        dv = 1'b0;
        for (int i = 0; i < 100 && cyc < c0 + 19; i++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (serial !== 1'b0 || fifo_count !== CW'(2)) begin
            n_fail++;
            $display("FAIL midframe_bit3: got ser=%b cnt=%0d required 0 2", serial, fifo_count);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (serial !== 1'b1 || fifo_count !== '0 || overflow !== 1'b0 ||
            active !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_async: got ser=%b cnt=%0d ovf=%b act=%b rdy=%b done=%b required 1 0 0 0 1 0",
                     serial, fifo_count, overflow, active, ready, done);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        g0 = got_q.size();
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (serial !== 1'b1 || active !== 1'b0 || fifo_count !== '0) bad++;
        end
        n_checks++;
        if (bad != 0 || got_q.size() != g0) begin
            n_fail++;
            $display("FAIL midframe_idle: got %0d non-idle cycles, %0d new frames required 0 0",
                     bad, got_q.size() - g0);
        end
        byte_in = 8'h5A; dv = 1'b1;
        exp_q.push_back(8'h5A);
        @(posedge clk); #1;
        dv = 1'b0;
        wait_quiet(200, to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL midframe_resume_timeout: transmitter did not go idle, required idle within 200 cycles");
        end
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin
                n_fail++;
                $display("FAIL midframe_resume_frame: got no frame required %h", e);
            end else begin
                f = got_q.pop_front();
                if (f.data !== e || !f.ok) begin
                    n_fail++;
                    $display("FAIL midframe_resume_frame: got %h ok=%0d required %h ok=1", f.data, f.ok, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_simultaneous();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bt_uart_tx_fifo.md
Name: bt_uart_tx_fifo

Overview:
Buffered 8N1 UART transmitter that drives the serial RX pin of the RN4871 Bluetooth module. This is the FPGA-to-Bluetooth direction.
- Accepts bytes from on-chip logic (e.g. the computer-side UART receiver, or a command generator) into a FIFO.
- Serializes the bytes back-to-back at CLKS_PER_BIT clocks per bit.
- Replaces the raw pass-through wire so that bursts are not lost and the link is fully clocked.

Parameters:
CLKS_PER_BIT, 217, clocks per UART bit (25 MHz / 115200); must be >= 2.
FIFO_DEPTH, 16, byte entries; power of two, >= 2.

Ports:
i_Clk  input  1  system clock (25 MHz)
i_Rst_L  input  1  asynchronous active-low reset
i_TX_DV  input  1  write strobe; byte accepted on rising edge when o_TX_Ready=1
i_TX_Byte  input  8  byte to queue
o_TX_Ready  output  1  FIFO not full (registered)
o_FIFO_Count  output  $clog2(FIFO_DEPTH)+1  entries currently queued (registered)
o_Overflow  output  1  sticky: a write was attempted while full
o_TX_Active  output  1  high from first start-bit cycle to last stop-bit cycle
o_TX_Serial  output  1  serial line to RN4871 RXD; idles high
o_TX_Done  output  1  one-cycle pulse per completed frame

Behaviour:
- Reset (async assert, sync release): FIFO empty, count=0, o_TX_Ready=1, o_Overflow=0, o_TX_Active=0, o_TX_Serial=1, o_TX_Done=0, state=IDLE. Reset asserted mid-frame: line goes high immediately and queued bytes are discarded.
- FIFO write rule:
  - Write accepted at an edge iff i_TX_DV=1 and count<FIFO_DEPTH, using the pre-edge count.
  - Write attempted while full: byte dropped; o_Overflow set and held until reset.
  - A pop in the same cycle does not make room for a write attempted while full.
- Simultaneous write and pop: count unchanged and FIFO order preserved.
- o_TX_Ready = (count < FIFO_DEPTH), registered alongside count.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles, for 10*CLKS_PER_BIT cycles per frame.
- State machine:
  - IDLE: line=1; if count>0, pop head into shift register, go to START.
  - START: line=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: line=shift[idx] for CLKS_PER_BIT cycles; idx increments 0..7; after idx 7, go to STOP.
  - STOP: line=1 for CLKS_PER_BIT cycles; on the final cycle, pulse o_TX_Done.
    - If count>0, pop and go directly to START, with no idle gap: the next start bit begins the cycle after the last stop cycle.
    - Otherwise go to IDLE.
- Latency:
  - Write to an empty, idle block: o_TX_Serial falls on the 2nd rising edge after the edge that accepted the byte.
  - o_TX_Active rises on the same edge and falls on the edge after the last stop cycle when nothing is queued. With back-to-back frames it stays high throughout.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
- Widths:
  - Bit index: 3 bits.
  - Baud counter: $clog2(CLKS_PER_BIT) bits.
  - FIFO pointers: $clog2(FIFO_DEPTH) bits, wrapping naturally.
  - Count saturates neither way; it is guarded by the write/pop rules.
- All outputs are registered. o_TX_Serial is glitch-free.

Test Plan:
- Use CLKS_PER_BIT=4 and FIFO_DEPTH=4 for speed.
- Single byte: after reset, write 0x35 -> line 1, then start 0, then bits 1,0,1,0,1,1,0,0, then stop 1, each 4 cycles. First low on 2nd edge after the write. One o_TX_Done pulse; o_TX_Active high for 40 cycles; count returns to 0.
- Burst: write 0xA5,0x3C,0xFF,0x00 on consecutive cycles -> all four frames sent in order with no idle cycles between stop and start; 4 o_TX_Done pulses; o_TX_Active continuously high for 160 cycles.
- Overflow: write 6 bytes 0x01..0x06 on consecutive cycles while 0x01 is transmitting:
  - 0x01 is popped at cycle 2, so 0x02..0x05 fill the FIFO and 0x06 is dropped.
  - o_TX_Ready=0 while full; o_Overflow=1 and stays 1.
  - Output sequence is 0x01..0x05.
- Simultaneous: hold FIFO at count=2 and write on the exact cycle STOP pops the next byte -> count stays 2 and byte order is intact.
- Reset mid-frame: assert i_Rst_L=0 during DATA bit 3 of 0x55 with 2 bytes queued -> o_TX_Serial=1 with no clock edge, count=0, o_Overflow=0. After release the line stays idle until a new write.
